// File: rtl/lif_pkg.sv
// Shared types and sizing helpers for the LIF neuron sequencer.
package lif_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_W = 2'b00,
        OP_LOAD_I = 2'b01,
        OP_RUN    = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_RUN   = 2'b10,
        ST_CLEAR = 2'b11
    } state_e;

    // Holds 1..64 steps plus the zero that marks the done cycle.
    localparam int STEPS_W = 7;

    function automatic int lif_inputs(input int n_stages);
        return 32'sd1 << n_stages;
    endfunction

    function automatic int lif_bytes(input int n_stages);
        int b;
        b = lif_inputs(n_stages) / 32'sd8;
        return (b < 32'sd1) ? 32'sd1 : b;
    endfunction

endpackage

// File: rtl/lif_sequencer_if.sv
// Valid/ready command byte channel between host and sequencer.
interface lif_sequencer_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_data;

    modport master (output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/lif_spike_counter.sv
// Saturating spike counter plus optional 8-step spike raster.
// Raster register exists only when LIF_SEQ_SPIKE_RASTER_EN is defined.
module lif_spike_counter #(
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic                spike_i,
    output logic [CNT_BITS-1:0] count_o,
    output logic [7:0]          raster_o
);

    logic [CNT_BITS-1:0] count_q;

    // Count spikes on step cycles, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && spike_i && (count_q != {CNT_BITS{1'b1}})) begin
            count_q <= count_q + CNT_BITS'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign count_o = count_q;

`ifdef LIF_SEQ_SPIKE_RASTER_EN
    logic [7:0] raster_q;

    // Newest step lands in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raster_q <= 8'h00;
        end else if (clr_i) begin
            raster_q <= 8'h00;
        end else if (en_i) begin
            raster_q <= {raster_q[6:0], spike_i};
        end else begin
            raster_q <= raster_q;
        end
    end

    assign raster_o = raster_q;
`else
    assign raster_o = 8'h00;
`endif

endmodule

// File: rtl/lif_sequencer.sv
// Command-driven sequencer for one LIF neuron: loads weights/inputs, clears, runs steps.
// Optional spike raster via LIF_SEQ_SPIKE_RASTER_EN (see lif_spike_counter).
module lif_sequencer
    import lif_pkg::*;
#(
    parameter int N_STAGES = 5,
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    lif_sequencer_if.slave      cfg,
    output logic [7:0]          nrn_byte,
    output logic                nrn_load_en,
    output logic                nrn_load_weights,
    output logic                nrn_step,
    output logic                nrn_clear,
    input  logic                nrn_spike,
    output logic                busy,
    output logic                done,
    output logic [CNT_BITS-1:0] spike_count,
    output logic [7:0]          spike_raster
);

    localparam int BYTES = lif_bytes(N_STAGES);
    localparam int BL_W  = $clog2(BYTES + 1);

    state_e             state_q, state_d;
    logic [BL_W-1:0]    bytes_left_q, bytes_left_d;
    logic [STEPS_W-1:0] steps_left_q, steps_left_d;
    logic               load_w_q, load_w_d;

    logic [7:0] byte_q, byte_d;
    logic       load_en_q, load_en_d;
    logic       step_q, step_d;
    logic       clear_q, clear_d;
    logic       done_q, done_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;

    logic accept_s;
    logic run_start_s;
    op_e  op_s;

    assign accept_s    = cfg.cfg_valid && ready_q;
    assign op_s        = op_e'(cfg.cfg_data[7:6]);
    assign run_start_s = accept_s && (state_q == ST_IDLE) && (op_s == OP_RUN);

    // State and framing counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bytes_left_q <= '0;
            steps_left_q <= '0;
            load_w_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bytes_left_q <= bytes_left_d;
            steps_left_q <= steps_left_d;
            load_w_q     <= load_w_d;
        end
    end

    // Next state: decode headers in IDLE, count payload bytes and steps.
    always_comb begin
        state_d      = state_q;
        bytes_left_d = bytes_left_q;
        steps_left_d = steps_left_q;
        load_w_d     = load_w_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (op_s)
                        OP_LOAD_W, OP_LOAD_I: begin
                            state_d      = ST_LOAD;
                            bytes_left_d = BL_W'(BYTES);
                            load_w_d     = (op_s == OP_LOAD_W);
                        end
                        OP_RUN: begin
                            state_d      = ST_RUN;
                            steps_left_d = {1'b0, cfg.cfg_data[5:0]} + 7'd1;
                        end
                        OP_CLEAR: begin
                            state_d = ST_CLEAR;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    bytes_left_d = bytes_left_q - BL_W'(1);
                    state_d      = (bytes_left_q == BL_W'(1)) ? ST_IDLE : ST_LOAD;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                // steps_left == 0 is the trailing done cycle.
                if (steps_left_q != 7'd0) begin
                    steps_left_d = steps_left_q - 7'd1;
                    state_d      = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next-values derived from the upcoming state so every output is a flop.
    always_comb begin
        byte_d    = byte_q;
        load_en_d = 1'b0;
        done_d    = 1'b0;
        step_d    = (state_d == ST_RUN) && (steps_left_d != 7'd0);
        clear_d   = (state_d == ST_CLEAR);
        ready_d   = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        busy_d    = (state_d != ST_IDLE);
        if ((state_q == ST_LOAD) && accept_s) begin
            byte_d    = cfg.cfg_data;
            load_en_d = 1'b1;
            done_d    = (bytes_left_q == BL_W'(1));
        end else begin
            done_d = (state_d == ST_CLEAR) ||
                     ((state_d == ST_RUN) && (steps_left_d == 7'd0));
        end
    end

    // Registered neuron controls and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q    <= 8'h00;
            load_en_q <= 1'b0;
            step_q    <= 1'b0;
            clear_q   <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            byte_q    <= byte_d;
            load_en_q <= load_en_d;
            step_q    <= step_d;
            clear_q   <= clear_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    lif_spike_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_spike_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (run_start_s),
        .en_i     (step_q),
        .spike_i  (nrn_spike),
        .count_o  (spike_count),
        .raster_o (spike_raster)
    );

    assign cfg.cfg_ready    = ready_q;
    assign nrn_byte         = byte_q;
    assign nrn_load_en      = load_en_q;
    assign nrn_load_weights = load_w_q;
    assign nrn_step         = step_q;
    assign nrn_clear        = clear_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule
